adbg_top_select: RTL and testbench
==================================

# adbg_top_select

Parametrised top-level chain selector for the advanced debug interface, placed between the TAP controller and the per-module debug units. It holds the main data shift register and a registered module ID, and it decodes select commands into one-hot module selects that honour per-module inhibits. It muxes TDO from the selected module. It adds behaviour the earlier top level lacked: a configurable module count, an explicit "no module selected" state, range and inhibit error detection, and a shiftable status word readable over JTAG while no module is selected.

## Interface
- NB_MODULES, 4, number of attached debug modules (1..2**MODULE_ID_LEN)
- MODULE_ID_LEN, 2, width of module ID field in select command
- DATAREG_LEN, 64, main shift register length (≥ MODULE_ID_LEN+1)
- STATUS_LEN (derived, = MODULE_ID_LEN+4), status word length
- tck_i  in  1  JTAG TCK; the only clock
- rst_i  in  1  reset, asynchronous and active-high
- tdi_i  in  1  JTAG TDI
- tdo_o  out  1  JTAG TDO (combinational mux)
- shift_dr_i, capture_dr_i, update_dr_i  in  1 each  TAP state strobes
- debug_select_i  in  1  debug IR instruction active
- data_register_o  out  DATAREG_LEN  main shift register, fanned out to all modules
- module_select_o  out  NB_MODULES  one-hot select; all zero when none is selected
- module_inhibit_i  in  NB_MODULES  per-module request to block a new selection
- module_tdo_i  in  NB_MODULES  per-module TDO
- module_id_o  out  MODULE_ID_LEN  registered module ID
- module_valid_o  out  1  a module is currently selected
- sel_err_o  out  1  OR of the sticky range and inhibit error flags

## Operation
- Shift reg: on posedge tck_i with debug_select_i & shift_dr_i: sr <= {tdi_i, sr[DATAREG_LEN-1:1]}. Otherwise it holds.
- Select command: sr[DATAREG_LEN-1]==1. ID field = sr[DATAREG_LEN-2 -: MODULE_ID_LEN].
- On debug_select_i & update_dr_i & select command:
  - If any module_inhibit_i bit is set: the selection is ignored. id and valid hold. err_inhibit <= 1.
  - Else if ID ≥ NB_MODULES: valid <= 0, id <= ID, err_range <= 1, err_inhibit <= 0.
  - Else: id <= ID, valid <= 1, both error flags <= 0.
- Update with sr MSB 0: no effect on id, valid or the error flags. It is a module command.
- module_select_o[i] = valid & (id==i).
- Status word, LSB first:
  - bit0 valid
  - bit1 err_range
  - bit2 err_inhibit
  - bit3 |module_inhibit_i
  - bits[STATUS_LEN-1:4] id
- Status reg: loaded on debug_select_i & capture_dr_i. On debug_select_i & shift_dr_i: st <= {1'b0, st[STATUS_LEN-1:1]}.
- tdo_o:
  - valid=1: module_tdo_i[id].
  - valid=0: st[0]. Reads 0 once the status word is exhausted.
- If update_dr_i and capture_dr_i coincide, which is illegal from the TAP: both actions occur. Status captures the pre-update values.
- Shift with debug_select_i low: no register changes.

## Timing
- Reset values:
  - sr=0, id=0, valid=0, err flags=0, st=0.
  - Hence module_select_o=0, module_id_o=0, module_valid_o=0, sel_err_o=0, tdo_o=0.
- Reset asserted mid-shift or mid-update clears everything immediately (async). The first legal select after release is accepted normally.
- A select takes effect at the update_dr_i edge. module_select_o, module_id_o and the TDO source change after that same edge, one cycle of latency.
- Inhibit is sampled at the update edge only. An inhibit that drops before the edge allows the select.
- The status word is valid on tdo_o from the first shift cycle after capture. Bit k is on tdo_o after k shift edges.
- tdo_o is combinational. The TAP wrapper retimes it on the negedge.

## Test plan
- Reset, then capture and shift 6 bits (MODULE_ID_LEN=2) -> tdo sequence 0,0,0,0,0,0. module_select_o=0000.
- Shift select cmd MSB=1, ID=2, then update -> module_select_o=0100, module_id_o=2, module_valid_o=1. tdo_o follows module_tdo_i[2] while module_tdo_i toggles.
- With ID 2 selected, hold module_inhibit_i=0010 and select ID=0 -> id stays 2, sel_err_o=1. A later select of ID 0 with inhibit=0 clears sel_err_o and gives module_select_o=0001.
- NB_MODULES=3, select ID=3 -> module_valid_o=0, module_select_o=000, sel_err_o=1. Capture and shift -> tdo bits 0,1,0,0,1,1.
- Update with MSB=0 while ID 1 is selected -> selection unchanged and sel_err_o unchanged. data_register_o equals the 64 bits shifted in.
- Assert rst_i mid-shift with ID 1 selected -> all outputs return to 0 in the same cycle. After release, select ID 1 -> module_select_o=0010.

Source files
------------

// File: rtl/adbg_top_select.sv
// Top-level chain selector for the advanced debug interface: main data register,
// module select decode with inhibit and range errors, status word and TDO mux.
module adbg_top_select #(
    parameter int NB_MODULES    = 4,
    parameter int MODULE_ID_LEN = 2,
    parameter int DATAREG_LEN   = 64
) (
    input  logic                     tck_i,
    input  logic                     rst_i,
    input  logic                     tdi_i,
    output logic                     tdo_o,
    input  logic                     shift_dr_i,
    input  logic                     capture_dr_i,
    input  logic                     update_dr_i,
    input  logic                     debug_select_i,
    output logic [DATAREG_LEN-1:0]   data_register_o,
    output logic [NB_MODULES-1:0]    module_select_o,
    input  logic [NB_MODULES-1:0]    module_inhibit_i,
    input  logic [NB_MODULES-1:0]    module_tdo_i,
    output logic [MODULE_ID_LEN-1:0] module_id_o,
    output logic                     module_valid_o,
    output logic                     sel_err_o
);
    localparam int STATUS_LEN = MODULE_ID_LEN + 4;
    localparam int ID_SPAN    = 2 ** MODULE_ID_LEN;

    logic [DATAREG_LEN-1:0]   sr;
    logic [MODULE_ID_LEN-1:0] id;
    logic                     valid;
    logic                     err_range;
    logic                     err_inhibit;
    logic [STATUS_LEN-1:0]    st;

    logic                     do_shift;
    logic                     do_capture;
    logic                     do_select;
    logic                     any_inhibit;
    logic                     id_out_of_range;
    logic [MODULE_ID_LEN-1:0] cmd_id;
    logic [ID_SPAN-1:0]       tdo_padded;

    assign do_shift        = debug_select_i & shift_dr_i;
    assign do_capture      = debug_select_i & capture_dr_i;
    assign do_select       = debug_select_i & update_dr_i & sr[DATAREG_LEN-1];
    assign cmd_id          = sr[DATAREG_LEN-2 -: MODULE_ID_LEN];
    assign any_inhibit     = |module_inhibit_i;
    // Widened by one bit so NB_MODULES == 2**MODULE_ID_LEN is representable.
    assign id_out_of_range = {1'b0, cmd_id} >= (MODULE_ID_LEN+1)'(NB_MODULES);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of block evaluation order.
    always_ff @(posedge tck_i or posedge rst_i) begin
        if (rst_i) begin
            sr <= '0;
        end else if (do_shift) begin
            sr <= {tdi_i, sr[DATAREG_LEN-1:1]};
        end
    end

    always_ff @(posedge tck_i or posedge rst_i) begin
        if (rst_i) begin
            id          <= '0;
            valid       <= 1'b0;
            err_range   <= 1'b0;
            err_inhibit <= 1'b0;
        end else if (do_select) begin
            if (any_inhibit) begin
                err_inhibit <= 1'b1;
            end else if (id_out_of_range) begin
                id          <= cmd_id;
                valid       <= 1'b0;
                err_range   <= 1'b1;
                err_inhibit <= 1'b0;
            end else begin
                id          <= cmd_id;
                valid       <= 1'b1;
                err_range   <= 1'b0;
                err_inhibit <= 1'b0;
            end
        end
    end

    // Capture sees the selection state from before a coincident update.
    always_ff @(posedge tck_i or posedge rst_i) begin
        if (rst_i) begin
            st <= '0;
        end else if (do_capture) begin
            st <= {id, any_inhibit, err_inhibit, err_range, valid};
        end else if (do_shift) begin
            st <= {1'b0, st[STATUS_LEN-1:1]};
        end
    end

    for (genvar i = 0; i < NB_MODULES; i++) begin : g_sel
        assign module_select_o[i] = valid && (id == MODULE_ID_LEN'(i));
    end

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        tdo_padded                 = '0;
        tdo_padded[NB_MODULES-1:0] = module_tdo_i;
        tdo_o                      = valid ? tdo_padded[id] : st[0];
    end

    assign data_register_o = sr;
    assign module_id_o     = id;
    assign module_valid_o  = valid;
    assign sel_err_o       = err_range | err_inhibit;
endmodule

// File: tb/tb_adbg_top_select.sv
// Scoreboard bench: one 4-module and one 3-module selector share the stimulus;
// a behavioural model predicts each cycle's outputs, a monitor compares them.
module tb_adbg_top_select;
    logic       tck = 1'b0;
    logic       rst = 1'b1;
    logic       tdi = 1'b0;
    logic       sh = 1'b0, cap = 1'b0, upd = 1'b0, dsel = 1'b0;
    logic [3:0] inh = '0;
    logic [3:0] mtdo = '0;

    always #5 tck = ~tck;

    logic        tdo4, v4, e4;
    logic [63:0] dr4;
    logic [3:0]  sel4;
    logic [1:0]  id4;
    logic        tdo3, v3, e3;
    logic [63:0] dr3;
    logic [2:0]  sel3;
    logic [1:0]  id3;

    adbg_top_select #(.NB_MODULES(4), .MODULE_ID_LEN(2), .DATAREG_LEN(64)) dut4 (
        .tck_i(tck), .rst_i(rst), .tdi_i(tdi), .tdo_o(tdo4),
        .shift_dr_i(sh), .capture_dr_i(cap), .update_dr_i(upd), .debug_select_i(dsel),
        .data_register_o(dr4), .module_select_o(sel4), .module_inhibit_i(inh),
        .module_tdo_i(mtdo), .module_id_o(id4), .module_valid_o(v4), .sel_err_o(e4)
    );

    adbg_top_select #(.NB_MODULES(3), .MODULE_ID_LEN(2), .DATAREG_LEN(64)) dut3 (
        .tck_i(tck), .rst_i(rst), .tdi_i(tdi), .tdo_o(tdo3),
        .shift_dr_i(sh), .capture_dr_i(cap), .update_dr_i(upd), .debug_select_i(dsel),
        .data_register_o(dr3), .module_select_o(sel3), .module_inhibit_i(inh[2:0]),
        .module_tdo_i(mtdo[2:0]), .module_id_o(id3), .module_valid_o(v3), .sel_err_o(e3)
    );

    typedef struct packed {
        logic [3:0] sel;
        logic [1:0] id;
        logic       valid;
        logic       err;
        logic       tdo;
    } inst_exp_t;

    typedef struct packed {
        inst_exp_t   u4;
        inst_exp_t   u3;
        logic [63:0] dr;
    } exp_t;

    exp_t exp_q[$];
    event sample_ev;
    int   checks = 0;
    int   failures = 0;

    // Reference model: selection state plus the captured status word read by index.
    logic [63:0] m_sr;
    bit          m_valid[2];
    int          m_id[2];
    bit          m_er[2];
    bit          m_ei[2];
    int          st_word[2];
    int          st_pos[2];

    function automatic int nb_of(int k);
        return (k == 0) ? 4 : 3;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sr = '0;
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 0; m_id[k] = 0; m_er[k] = 0; m_ei[k] = 0;
            st_word[k] = 0; st_pos[k] = 0;
        end
    endtask

    task automatic model_edge();
        logic [63:0] old_sr;
        bit          any_inh;
        int          c;
        old_sr = m_sr;
        for (int k = 0; k < 2; k++) begin
            any_inh = (k == 0) ? |inh : |inh[2:0];
            if (dsel && cap) begin
                st_word[k] = int'(m_valid[k]) + 2 * int'(m_er[k]) + 4 * int'(m_ei[k])
                           + 8 * int'(any_inh) + 16 * m_id[k];
                st_pos[k] = 0;
            end else if (dsel && sh && st_pos[k] < 6) begin
                st_pos[k]++;
            end
            if (dsel && upd && old_sr[63]) begin
                c = int'(old_sr[62:61]);
                if (any_inh) begin
                    m_ei[k] = 1;
                end else if (c >= nb_of(k)) begin
                    m_valid[k] = 0; m_id[k] = c; m_er[k] = 1; m_ei[k] = 0;
                end else begin
                    m_valid[k] = 1; m_id[k] = c; m_er[k] = 0; m_ei[k] = 0;
                end
            end
        end
        if (dsel && sh) m_sr = {tdi, m_sr[63:1]};
    endtask

    function automatic inst_exp_t predict(int k);
        inst_exp_t  r;
        logic [3:0] t;
        t       = (k == 0) ? mtdo : {1'b0, mtdo[2:0]};
        r.valid = m_valid[k];
        r.id    = 2'(m_id[k]);
        r.err   = m_er[k] | m_ei[k];
        r.sel   = m_valid[k] ? 4'(1 << m_id[k]) : 4'b0;
        if (m_valid[k]) r.tdo = t[m_id[k]];
        else            r.tdo = (st_pos[k] < 6) ? st_word[k][st_pos[k]] : 1'b0;
        return r;
    endfunction

    task automatic push_expected();
        exp_t e;
        e.u4 = predict(0);
        e.u3 = predict(1);
        e.dr = m_sr;
        exp_q.push_back(e);
    endtask

    always begin
        exp_t e;
        @(sample_ev);
        check("exp_available", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sel4", 64'(sel4), 64'(e.u4.sel));
            check("id4", 64'(id4), 64'(e.u4.id));
            check("valid4", 64'(v4), 64'(e.u4.valid));
            check("err4", 64'(e4), 64'(e.u4.err));
            check("tdo4", 64'(tdo4), 64'(e.u4.tdo));
            check("dreg4", dr4, e.dr);
            check("sel3", 64'(sel3), 64'(e.u3.sel[2:0]));
            check("id3", 64'(id3), 64'(e.u3.id));
            check("valid3", 64'(v3), 64'(e.u3.valid));
            check("err3", 64'(e3), 64'(e.u3.err));
            check("tdo3", 64'(tdo3), 64'(e.u3.tdo));
            check("dreg3", dr3, e.dr);
        end
    end

    task automatic cycle(logic s, logic c, logic u, logic d, logic t, logic [3:0] i);
        @(negedge tck);
        sh = s; cap = c; upd = u; dsel = d; tdi = t; inh = i;
        mtdo = 4'($urandom);
        model_edge();
        push_expected();
        @(posedge tck);
        #2;
        -> sample_ev;
    endtask

    task automatic shift_word(logic [63:0] w);
        for (int i = 0; i < 64; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, w[i], 4'b0);
    endtask

    task automatic select_id(int id, logic [3:0] inh_at_update);
        logic [63:0] w;
        w = {$urandom, $urandom};
        w[63] = 1'b1;
        w[62:61] = 2'(id);
        shift_word(w);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, inh_at_update);
    endtask

    task automatic module_cmd();
        logic [63:0] w;
        w = {$urandom, $urandom};
        w[63] = 1'b0;
        shift_word(w);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0);
    endtask

    task automatic read_status(logic [3:0] inh_at_capture);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, inh_at_capture);
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'($urandom), 4'b0);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0);
    endtask

    task automatic reset_mid_shift();
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        push_expected();
        -> sample_ev;
        @(negedge tck);
        @(negedge tck);
        rst = 1'b0; sh = 1'b0; upd = 1'b0; dsel = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before the bench completed");
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        model_reset();
        #12;
        push_expected();
        -> sample_ev;
        @(negedge tck);
        rst = 1'b0;

        read_status(4'b0);
        select_id(2, 4'b0);
        idle(6);
        select_id(0, 4'b0010);
        idle(2);
        select_id(0, 4'b0);
        select_id(3, 4'b0);
        read_status(4'b0);
        select_id(1, 4'b0);
        module_cmd();
        idle(2);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'($urandom), 1'b1, 1'b0, 1'($urandom), 4'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0100);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0);
        select_id(1, 4'b0);
        reset_mid_shift();
        select_id(1, 4'b0);
        idle(2);

        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 5);
            case (op)
                0, 1: select_id($urandom_range(0, 3),
                                ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0);
                2: module_cmd();
                3: read_status(4'($urandom));
                4: for (int i = 0; i < 4; i++)
                       cycle(1'b1, 1'($urandom), 1'($urandom), 1'b0, 1'($urandom), 4'($urandom));
                default: begin
                    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'($urandom));
                    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'($urandom), 4'b0);
                end
            endcase
        end

        #20;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
